// File: rtl/fp_norm_pkg.sv
// Shared constants and helpers for the FMA normalise/round back end.
// Rounding-mode codes, fflags bit positions, special-result classes and packed constant builders.
package fp_norm_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [2:0] {
        SPC_NONE,
        SPC_NVNAN,
        SPC_QNAN,
        SPC_INF,
        SPC_ZERO
    } spc_e;

    // Both builders return a wide vector; callers keep the low 1+expW+mantW bits.
    function automatic logic [127:0] canonNan(input int expW, input int mantW);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < expW; i++) r |= 128'(1) << (mantW + i);
        r |= 128'(1) << (mantW - 1);
        return r;
    endfunction

    function automatic logic [127:0] maxFinite(input int expW, input int mantW);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < mantW; i++) r |= 128'(1) << i;
        for (int i = 1; i < expW; i++) r |= 128'(1) << (mantW + i);
        return r;
    endfunction

endpackage

// File: rtl/fp_round_core.sv
// Combinational rounding of a normalised magnitude: increment decision, carry,
// mode-dependent overflow result and exception flags.
module fp_round_core
    import fp_norm_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int IN_W   = 3*MANT_W+5
) (
    input  logic [IN_W-2:0]          i_mant,
    input  logic signed [EXP_W+2:0]  i_exp,
    input  logic                     i_sticky,
    input  logic                     i_sign,
    input  logic                     i_tiny,
    input  logic [2:0]               i_rm,
    output logic [EXP_W+MANT_W:0]    o_result,
    output logic [4:0]               o_flags
);

    localparam int KEEP_W = MANT_W + 1;
    localparam int REST_W = IN_W - MANT_W - 3;
    localparam logic [127:0] MAXF_FULL = maxFinite(EXP_W, MANT_W);
    localparam logic [EXP_W+MANT_W-1:0] MAXF = MAXF_FULL[EXP_W+MANT_W-1:0];
    localparam logic signed [EXP_W+2:0] EXP_OVF = (EXP_W+3)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+2:0] EXP_ZERO = '0;

    logic [KEEP_W-1:0]         w_kept;
    logic                      w_guard;
    logic                      w_stk;
    logic                      w_inexact;
    logic                      w_incr;
    logic                      w_of;
    logic                      w_ofInf;
    logic [KEEP_W:0]           w_sum;
    logic signed [EXP_W+2:0]   w_rndExp;
    logic [MANT_W-1:0]         w_frac;
    logic [EXP_W+MANT_W-1:0]   w_ofMag;

    assign w_kept    = i_mant[IN_W-2 -: KEEP_W];
    assign w_guard   = i_mant[REST_W];
    assign w_stk     = (|i_mant[REST_W-1:0]) | i_sticky;
    assign w_inexact = w_guard | w_stk;

    always_comb begin
        case (i_rm)
            RM_RNE:  w_incr = w_guard & (w_stk | w_kept[0]);
            RM_RDN:  w_incr = w_inexact & i_sign;
            RM_RUP:  w_incr = w_inexact & ~i_sign;
            RM_RMM:  w_incr = w_guard;
            default: w_incr = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_kept} + {{KEEP_W{1'b0}}, w_incr};

    // A subnormal that rounds into the hidden bit picks up exponent field 1 from the sum itself.
    always_comb begin
        if (i_exp == EXP_ZERO)
            w_rndExp = {{(EXP_W+2){1'b0}}, w_sum[MANT_W]};
        else
            w_rndExp = i_exp + {{(EXP_W+2){1'b0}}, w_sum[KEEP_W]};
    end

    assign w_frac = w_sum[KEEP_W] ? '0 : w_sum[MANT_W-1:0];
    assign w_of   = (w_rndExp >= EXP_OVF);

    always_comb begin
        case (i_rm)
            RM_RTZ:  w_ofInf = 1'b0;
            RM_RDN:  w_ofInf = i_sign;
            RM_RUP:  w_ofInf = ~i_sign;
            default: w_ofInf = 1'b1;
        endcase
    end

    assign w_ofMag  = w_ofInf ? {{EXP_W{1'b1}}, {MANT_W{1'b0}}} : MAXF;
    assign o_result = w_of ? {i_sign, w_ofMag} : {i_sign, w_rndExp[EXP_W-1:0], w_frac};

    always_comb begin
        o_flags          = '0;
        o_flags[FLAG_OF] = w_of;
        o_flags[FLAG_NX] = w_inexact | w_of;
        o_flags[FLAG_UF] = i_tiny & (w_inexact | w_of);
    end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage valid/ready normalise-and-round back end for the FMA datapath,
// producing a packed IEEE-754 result, per-beat flags and an accumulated fflags register.
module fp_norm_round_pipe
    import fp_norm_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int IN_W   = 3*MANT_W+5,
    parameter int LZC_W  = 7
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      Valid_i,
    output logic                      Ready_o,
    input  logic [IN_W-1:0]           Mant_i,
    input  logic [EXP_W+1:0]          Exp_i,
    input  logic                      Sign_i,
    input  logic [LZC_W-1:0]          Shift_num_i,
    input  logic                      Sticky_i,
    input  logic [2:0]                Rm_i,
    input  logic                      Nan_i,
    input  logic                      Inf_i,
    input  logic                      Invalid_i,
    output logic                      Valid_o,
    input  logic                      Ready_i,
    output logic [EXP_W+MANT_W:0]     Result_o,
    output logic [4:0]                Flags_o,
    output logic [4:0]                Fflags_o,
    input  logic                      Fflags_clr_i
);

    localparam int RES_W  = 1 + EXP_W + MANT_W;
    localparam int SE_W   = EXP_W + 3;
    localparam int WIDE_W = 2*IN_W + 1;
    localparam logic [127:0] CNAN_FULL = canonNan(EXP_W, MANT_W);
    localparam logic [RES_W-1:0] CNAN = CNAN_FULL[RES_W-1:0];
    localparam logic signed [SE_W-1:0] SE_ZERO = '0;
    localparam logic signed [SE_W-1:0] SE_ONE  = SE_W'(1);
    localparam logic signed [SE_W-1:0] RSH_SAT = SE_W'(IN_W + 2);
    localparam logic [4:0] NV_FLAGS = 5'(1) << FLAG_NV;

    logic                    r_s1Valid;
    logic [IN_W-2:0]         r_s1Mant;
    logic signed [SE_W-1:0]  r_s1Exp;
    logic                    r_s1Sticky;
    logic                    r_s1Tiny;
    logic                    r_s1Sign;
    logic [2:0]              r_s1Rm;
    spc_e                    r_s1Spc;
    logic                    r_s2Valid;
    logic [RES_W-1:0]        r_s2Result;
    logic [4:0]              r_s2Flags;
    logic [4:0]              r_fflags;

    logic                    w_s1Open;
    logic                    w_s2Open;
    logic                    w_outFire;
    logic signed [SE_W-1:0]  w_expExt;
    logic signed [SE_W-1:0]  w_diff;
    logic signed [SE_W-1:0]  w_rshRaw;
    logic [SE_W-1:0]         w_rsh;
    logic [SE_W-1:0]         w_lshAmt;
    logic [WIDE_W-1:0]       w_wide;
    logic [IN_W-2:0]         w_lsh;
    logic [IN_W-2:0]         w_norm;
    logic signed [SE_W-1:0]  w_nExp;
    logic                    w_nSticky;
    spc_e                    w_spc;
    logic [RES_W-1:0]        w_coreResult;
    logic [4:0]              w_coreFlags;
    logic [RES_W-1:0]        w_s2Result;
    logic [4:0]              w_s2Flags;

    assign w_s2Open  = ~r_s2Valid | Ready_i;
    assign w_s1Open  = ~r_s1Valid | w_s2Open;
    assign w_outFire = r_s2Valid & Ready_i;

    assign w_expExt = {Exp_i[EXP_W+1], Exp_i};
    assign w_diff   = w_expExt - SE_W'(Shift_num_i);
    assign w_rshRaw = SE_ONE - w_expExt;
    assign w_rsh    = (w_rshRaw > RSH_SAT) ? RSH_SAT : w_rshRaw;
    assign w_lshAmt = (w_diff >= SE_ONE) ? SE_W'(Shift_num_i) : w_expExt - SE_ONE;

    // The low half of the wide shift catches every bit pushed out by denormalisation.
    assign w_wide = {Mant_i[IN_W-2:0], {(IN_W+2){1'b0}}} >> w_rsh;
    assign w_lsh  = Mant_i[IN_W-2:0] << w_lshAmt;

    always_comb begin
        w_norm    = w_lsh;
        w_nExp    = w_diff;
        w_nSticky = Sticky_i;
        if (Mant_i[IN_W-1]) begin
            w_norm    = Mant_i[IN_W-1:1];
            w_nExp    = w_expExt + SE_ONE;
            w_nSticky = Sticky_i | Mant_i[0];
        end else if (w_expExt <= SE_ZERO) begin
            w_norm    = w_wide[WIDE_W-1 -: IN_W-1];
            w_nExp    = SE_ZERO;
            w_nSticky = Sticky_i | (|w_wide[IN_W+1:0]);
        end else if (w_diff < SE_ONE) begin
            w_nExp    = SE_ZERO;
        end
    end

    always_comb begin
        if (Rm_i > RM_RMM)                  w_spc = SPC_NVNAN;
        else if (Invalid_i)                 w_spc = SPC_NVNAN;
        else if (Nan_i)                     w_spc = SPC_QNAN;
        else if (Inf_i)                     w_spc = SPC_INF;
        else if (Mant_i == '0 && !Sticky_i) w_spc = SPC_ZERO;
        else                                w_spc = SPC_NONE;
    end

    fp_round_core #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W),
        .IN_W   (IN_W)
    ) u_round (
        .i_mant   (r_s1Mant),
        .i_exp    (r_s1Exp),
        .i_sticky (r_s1Sticky),
        .i_sign   (r_s1Sign),
        .i_tiny   (r_s1Tiny),
        .i_rm     (r_s1Rm),
        .o_result (w_coreResult),
        .o_flags  (w_coreFlags)
    );

    always_comb begin
        w_s2Result = w_coreResult;
        w_s2Flags  = w_coreFlags;
        case (r_s1Spc)
            SPC_NVNAN: begin w_s2Result = CNAN; w_s2Flags = NV_FLAGS; end
            SPC_QNAN:  begin w_s2Result = CNAN; w_s2Flags = '0; end
            SPC_INF:   begin w_s2Result = {r_s1Sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}}; w_s2Flags = '0; end
            SPC_ZERO:  begin w_s2Result = {r_s1Sign, {(RES_W-1){1'b0}}}; w_s2Flags = '0; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1Valid  <= 1'b0;
            r_s1Mant   <= '0;
            r_s1Exp    <= SE_ZERO;
            r_s1Sticky <= 1'b0;
            r_s1Tiny   <= 1'b0;
            r_s1Sign   <= 1'b0;
            r_s1Rm     <= RM_RNE;
            r_s1Spc    <= SPC_NONE;
        end else if (w_s1Open) begin
            r_s1Valid <= Valid_i;
            if (Valid_i) begin
                r_s1Mant   <= w_norm;
                r_s1Exp    <= w_nExp;
                r_s1Sticky <= w_nSticky;
                r_s1Tiny   <= ~w_norm[IN_W-2];
                r_s1Sign   <= Sign_i;
                r_s1Rm     <= Rm_i;
                r_s1Spc    <= w_spc;
            end
        end
    end

    // Stage-2 data only moves with a beat, so a stalled output holds steady.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2Valid  <= 1'b0;
            r_s2Result <= '0;
            r_s2Flags  <= '0;
        end else if (w_s2Open) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Result <= w_s2Result;
                r_s2Flags  <= w_s2Flags;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_fflags <= '0;
        else if (w_outFire)
            r_fflags <= Fflags_clr_i ? r_s2Flags : (r_fflags | r_s2Flags);
        else if (Fflags_clr_i)
            r_fflags <= '0;
    end

    assign Ready_o  = w_s1Open;
    assign Valid_o  = r_s2Valid;
    assign Result_o = r_s2Result;
    assign Flags_o  = r_s2Flags;
    assign Fflags_o = r_fflags;

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Directed table-driven bench for fp_norm_round_pipe (fp32 defaults) plus
// hand-written backpressure, mid-burst reset and fflags sequences.
module tb_fp_norm_round_pipe;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;
    localparam logic [73:0] HID    = 74'd1 << 72;
    localparam logic [73:0] GRD    = 74'd1 << 48;
    localparam logic [73:0] ONES25 = ((74'd1 << 25) - 74'd1) << 48;
    localparam logic [73:0] ONES24 = ((74'd1 << 24) - 74'd1) << 49;
    localparam int NVEC = 26;

    typedef struct {
        logic [73:0] mant;
        logic [9:0]  expv;
        logic [6:0]  shamt;
        logic        sgn;
        logic        stk;
        logic [2:0]  rmode;
        logic        inv;
        logic        nan;
        logic        inf;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        validIn = 1'b0;
    logic        readyOut;
    logic [73:0] mant = '0;
    logic [9:0]  expIn = '0;
    logic        signIn = 1'b0;
    logic [6:0]  shiftNum = '0;
    logic        stickyIn = 1'b0;
    logic [2:0]  rm = 3'b000;
    logic        nanIn = 1'b0;
    logic        infIn = 1'b0;
    logic        invalidIn = 1'b0;
    logic        validOut;
    logic        readyIn = 1'b1;
    logic [31:0] result;
    logic [4:0]  flags;
    logic [4:0]  fflags;
    logic        fflagsClr = 1'b0;

    int passCnt = 0;
    int totalCnt = 0;

    vec_t vecs [NVEC];
    vec_t burst [4];

    fp_norm_round_pipe dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .Valid_i      (validIn),
        .Ready_o      (readyOut),
        .Mant_i       (mant),
        .Exp_i        (expIn),
        .Sign_i       (signIn),
        .Shift_num_i  (shiftNum),
        .Sticky_i     (stickyIn),
        .Rm_i         (rm),
        .Nan_i        (nanIn),
        .Inf_i        (infIn),
        .Invalid_i    (invalidIn),
        .Valid_o      (validOut),
        .Ready_i      (readyIn),
        .Result_o     (result),
        .Flags_o      (flags),
        .Fflags_o     (fflags),
        .Fflags_clr_i (fflagsClr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [73:0] m, input int e, input int sh,
                                   input logic s, input logic st, input logic [2:0] r,
                                   input logic [2:0] spc, input logic [31:0] res,
                                   input logic [4:0] flg);
        vec_t v;
        v.mant  = m;
        v.expv  = 10'(e);
        v.shamt = 7'(sh);
        v.sgn   = s;
        v.stk   = st;
        v.rmode = r;
        v.inv   = spc[2];
        v.nan   = spc[1];
        v.inf   = spc[0];
        v.res   = res;
        v.flg   = flg;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
        totalCnt++;
        if (act !== expv)
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        else
            passCnt++;
    endtask

    task automatic applyStimulus(input vec_t v);
        mant      = v.mant;
        expIn     = v.expv;
        shiftNum  = v.shamt;
        signIn    = v.sgn;
        stickyIn  = v.stk;
        rm        = v.rmode;
        invalidIn = v.inv;
        nanIn     = v.nan;
        infIn     = v.inf;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        checkVal({tag, " valid"}, 32'(validOut), 32'd1);
        checkVal({tag, " result"}, result, v.res);
        checkVal({tag, " flags"}, 32'(flags), 32'(v.flg));
    endtask

    // One beat in, checked exactly two cycles after it is presented.
    task automatic sendVec(input vec_t v, input string tag);
        @(negedge clk);
        applyStimulus(v);
        validIn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        validIn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput(v, tag);
    endtask

    initial begin
        int sent;
        int got;
        int cyc;
        int stray;
        logic sawLow;
        logic acc;

        vecs[0]  = mkVec(HID,              127, 0, 0, 0, RNE, 3'b000, 32'h3F800000, 5'h00);
        vecs[1]  = mkVec(HID | GRD,        127, 0, 0, 0, RNE, 3'b000, 32'h3F800000, 5'h01);
        vecs[2]  = mkVec(HID | GRD,        127, 0, 0, 0, RUP, 3'b000, 32'h3F800001, 5'h01);
        vecs[3]  = mkVec(HID | GRD,        127, 0, 0, 0, RMM, 3'b000, 32'h3F800001, 5'h01);
        vecs[4]  = mkVec(HID | GRD,        127, 0, 1, 0, RDN, 3'b000, 32'hBF800001, 5'h01);
        vecs[5]  = mkVec(HID,              255, 0, 0, 0, RNE, 3'b000, 32'h7F800000, 5'h05);
        vecs[6]  = mkVec(HID,              255, 0, 0, 0, RTZ, 3'b000, 32'h7F7FFFFF, 5'h05);
        vecs[7]  = mkVec(HID,              255, 0, 1, 0, RDN, 3'b000, 32'hFF800000, 5'h05);
        vecs[8]  = mkVec(HID,                0, 0, 0, 0, RNE, 3'b000, 32'h00400000, 5'h00);
        vecs[9]  = mkVec(HID | 74'd1,       -5, 0, 0, 0, RNE, 3'b000, 32'h00020000, 5'h03);
        vecs[10] = mkVec(HID,              127, 0, 0, 0, 3'b101, 3'b000, 32'h7FC00000, 5'h10);
        vecs[11] = mkVec(HID << 1,         127, 0, 0, 0, RNE, 3'b000, 32'h40000000, 5'h00);
        vecs[12] = mkVec(74'd1 << 70,      129, 2, 0, 0, RNE, 3'b000, 32'h3F800000, 5'h00);
        vecs[13] = mkVec(74'd1 << 70,        2, 2, 0, 0, RNE, 3'b000, 32'h00400000, 5'h00);
        vecs[14] = mkVec(HID | (74'd1 << 49) | GRD, 127, 0, 0, 0, RNE, 3'b000, 32'h3F800002, 5'h01);
        vecs[15] = mkVec(ONES25,           127, 0, 0, 0, RNE, 3'b000, 32'h40000000, 5'h01);
        vecs[16] = mkVec(ONES24,             0, 0, 0, 0, RNE, 3'b000, 32'h00800000, 5'h03);
        vecs[17] = mkVec(HID,              255, 0, 1, 0, RUP, 3'b000, 32'hFF7FFFFF, 5'h05);
        vecs[18] = mkVec(HID,              255, 0, 0, 0, RDN, 3'b000, 32'h7F7FFFFF, 5'h05);
        vecs[19] = mkVec(ONES25,           254, 0, 0, 0, RNE, 3'b000, 32'h7F800000, 5'h05);
        vecs[20] = mkVec(HID,              127, 0, 0, 0, RNE, 3'b100, 32'h7FC00000, 5'h10);
        vecs[21] = mkVec(HID,              127, 0, 0, 0, RNE, 3'b010, 32'h7FC00000, 5'h00);
        vecs[22] = mkVec(HID,              127, 0, 1, 0, RNE, 3'b001, 32'hFF800000, 5'h00);
        vecs[23] = mkVec(74'd0,            127, 0, 1, 0, RNE, 3'b000, 32'h80000000, 5'h00);
        vecs[24] = mkVec(HID | GRD,        127, 0, 1, 0, RTZ, 3'b000, 32'hBF800000, 5'h01);
        vecs[25] = mkVec(HID,              127, 0, 0, 1, RUP, 3'b000, 32'h3F800001, 5'h01);

        for (int k = 0; k < 4; k++)
            burst[k] = mkVec(HID, 127 + k, 0, 0, 0, RNE, 3'b000,
                             {1'b0, 8'(127 + k), 23'd0}, 5'h00);

        $display("[TB] reset and idle state");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("reset Valid_o", 32'(validOut), 32'd0);
        checkVal("reset Ready_o", 32'(readyOut), 32'd1);
        checkVal("reset Result_o", result, 32'd0);
        checkVal("reset Flags_o", 32'(flags), 32'd0);
        checkVal("reset Fflags_o", 32'(fflags), 32'd0);

        $display("[TB] directed vectors");
        for (int i = 0; i < NVEC; i++)
            sendVec(vecs[i], $sformatf("vec%0d", i));

        $display("[TB] backpressure burst");
        sent = 0;
        got = 0;
        cyc = 0;
        sawLow = 1'b0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            readyIn = (cyc >= 3);
            if (sent < 4) begin
                applyStimulus(burst[sent]);
                validIn = 1'b1;
            end else begin
                validIn = 1'b0;
            end
            #1;
            if (!readyOut) sawLow = 1'b1;
            if (validOut && readyIn) begin
                checkVal($sformatf("burst order beat%0d", got), result, burst[got].res);
                got++;
            end else if (validOut) begin
                checkVal("stall hold", result, burst[got].res);
            end
            acc = validIn && readyOut;
            @(posedge clk);
            if (acc) sent++;
            cyc++;
        end
        validIn = 1'b0;
        readyIn = 1'b1;
        checkVal("burst Ready_o dropped", 32'(sawLow), 32'd1);
        checkVal("burst beats out", 32'(got), 32'd4);
        @(negedge clk);
        #1;
        checkVal("burst no extra beat", 32'(validOut), 32'd0);

        $display("[TB] reset mid-burst");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            applyStimulus(burst[k]);
            validIn = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        validIn = 1'b0;
        #1;
        checkVal("in-flight before reset", 32'(validOut), 32'd1);
        rst = 1'b1;
        #1;
        checkVal("Valid_o during reset", 32'(validOut), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (validOut) stray++;
        end
        checkVal("stale beats after reset", 32'(stray), 32'd0);
        checkVal("Fflags after reset", 32'(fflags), 32'd0);

        $display("[TB] fflags accumulate and clear");
        sendVec(vecs[1], "ff inexact");
        sendVec(vecs[5], "ff overflow");
        @(negedge clk);
        #1;
        checkVal("fflags accumulated", 32'(fflags), 32'h05);
        sendVec(vecs[1], "ff clr beat");
        fflagsClr = 1'b1;
        @(negedge clk);
        fflagsClr = 1'b0;
        #1;
        checkVal("fflags clear with beat", 32'(fflags), 32'h01);
        fflagsClr = 1'b1;
        @(negedge clk);
        fflagsClr = 1'b0;
        #1;
        checkVal("fflags clear alone", 32'(fflags), 32'h00);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
